bsg_rotate_right_rr_server: RTL and testbench

- Shares one combinational width_p-bit rotate-right unit among num_req_p requesters.
- Round-robin arbitration picks one requester per cycle. The winner's word is rotated right by its own amount and captured into a single output register.
- The output register uses a valid/yumi handshake.
- Sits between multiple alignment clients (e.g. packet realigners, lane shufflers) and their consumers, so that only one rotator is instantiated.

---
 rtl/bsg_rotate_right_rr_server.sv | 100 ++++++++++
 tb/tb_bsg_rotate_right_rr_server.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_rotate_right_rr_server.sv
`default_nettype none
// =============================================================================
// Module  : bsg_rotate_right_rr_server
// Brief   : One rotate-right unit shared round-robin among num_req_p requesters.
// Rev     : 1.0
// =============================================================================
module bsg_rotate_right_rr_server #(
    parameter int width_p   = 32,
    parameter int num_req_p = 4,
    localparam int lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1,
    localparam int lg_req_lp   = $clog2(num_req_p)
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [num_req_p-1:0]             v_i,
    input  logic [num_req_p*width_p-1:0]     data_i,
    input  logic [num_req_p*lg_width_lp-1:0] rot_i,
    output logic [num_req_p-1:0]             ready_o,
    output logic                             v_o,
    output logic [width_p-1:0]               data_o,
    output logic [lg_req_lp-1:0]             id_o,
    output logic [lg_width_lp-1:0]           rot_o,
    input  logic                             yumi_i
);

    logic [width_p-1:0]     data_arr [num_req_p];
    logic [lg_width_lp-1:0] rot_arr  [num_req_p];

    for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
        assign data_arr[g] = data_i[g*width_p +: width_p];
        assign rot_arr[g]  = rot_i[g*lg_width_lp +: lg_width_lp];
    end

    logic                   v_q;
    logic [width_p-1:0]     data_q;
    logic [lg_req_lp-1:0]   id_q;
    logic [lg_width_lp-1:0] rot_q;
    logic [lg_req_lp-1:0]   last_grant_q;

    logic                   found;
    logic [lg_req_lp-1:0]   winner;
    logic                   slot_free;
    logic                   xfer;
    logic [lg_width_lp-1:0] sel_rot;
    logic [lg_width_lp-1:0] rot_amt;
    logic [width_p-1:0]     data_d;

    // Search starts just after the last winner, so a fresh reset favours requester 0.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int i = 1; i <= num_req_p; i++) begin
            idx = (int'(last_grant_q) + i) % num_req_p;
            if (!found && v_i[lg_req_lp'(idx)]) begin
                found  = 1'b1;
                winner = lg_req_lp'(idx);
            end
        end
    end

    assign slot_free = ~v_q | yumi_i;
    assign xfer      = found & slot_free;
    assign ready_o   = (xfer & reset_n_i) ? (num_req_p'(1) << winner) : '0;

    assign sel_rot = rot_arr[winner];
    assign rot_amt = lg_width_lp'(int'(sel_rot) % width_p);
    assign data_d  = width_p'({data_arr[winner], data_arr[winner]} >> rot_amt);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q          <= 1'b0;
            data_q       <= '0;
            id_q         <= '0;
            rot_q        <= '0;
            last_grant_q <= lg_req_lp'(num_req_p - 1);
        end else if (xfer) begin
            v_q          <= 1'b1;
            data_q       <= data_d;
            id_q         <= winner;
            rot_q        <= sel_rot;
            last_grant_q <= winner;
        end else if (yumi_i) begin
            v_q          <= 1'b0;
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;
    assign id_o   = id_q;
    assign rot_o  = rot_q;

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        yumi_i |-> v_q);
    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0(ready_o));

endmodule
`default_nettype wire

// File: tb/tb_bsg_rotate_right_rr_server.sv
`default_nettype none
// =============================================================================
// Module  : tb_bsg_rotate_right_rr_server
// Brief   : Scoreboard bench with a bit-level rotate model and round-robin model.
// Rev     : 1.0
// =============================================================================
module tb_bsg_rotate_right_rr_server;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int LW = 5;
    localparam int LR = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  v_i;
    logic [N*W-1:0]  data_i;
    logic [N*LW-1:0] rot_i;
    logic [N-1:0]  ready_o;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic [LR-1:0] id_o;
    logic [LW-1:0] rot_o;
    logic          yumi_i;
    logic          want_yumi;

    logic [W-1:0]  d_arr [N];
    logic [LW-1:0] r_arr [N];

    typedef struct packed {
        logic [LR-1:0] id;
        logic [W-1:0]  data;
        logic [LW-1:0] rot;
    } res_t;

    res_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   m_v;
    int   m_lg;

    always #5 clk = ~clk;

    always_comb begin
        data_i = '0;
        rot_i  = '0;
        for (int k = 0; k < N; k++) begin
            data_i[k*W +: W]   = d_arr[k];
            rot_i[k*LW +: LW]  = r_arr[k];
        end
    end

    assign yumi_i = want_yumi & v_o;

    bsg_rotate_right_rr_server #(.width_p(W), .num_req_p(N)) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .v_i      (v_i),
        .data_i   (data_i),
        .rot_i    (rot_i),
        .ready_o  (ready_o),
        .v_o      (v_o),
        .data_o   (data_o),
        .id_o     (id_o),
        .rot_o    (rot_o),
        .yumi_i   (yumi_i)
    );

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Result bit j takes source bit (j+rot) mod W.
    function automatic logic [W-1:0] ref_rot(logic [W-1:0] d, int r);
        logic [W-1:0] res;
        for (int j = 0; j < W; j++) res[j] = d[(j + r) % W];
        return res;
    endfunction

    // Reference model: predicts grants and pushes expected results.
    initial begin : model
        bit           slot;
        bit           found;
        int           w;
        logic [N-1:0] er;
        res_t         e;
        m_v  = 1'b0;
        m_lg = N - 1;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_v  = 1'b0;
                m_lg = N - 1;
                sb.delete();
            end else begin
                chk("v_o", 64'(v_o), 64'(m_v));
                slot  = !m_v || yumi_i;
                found = 1'b0;
                w     = 0;
                for (int i = 1; i <= N; i++) begin
                    if (!found && v_i[LR'((m_lg + i) % N)]) begin
                        found = 1'b1;
                        w     = (m_lg + i) % N;
                    end
                end
                er = '0;
                if (found && slot) er[LR'(w)] = 1'b1;
                chk("ready_o", 64'(ready_o), 64'(er));
                if (found && slot) begin
                    e.id   = LR'(w);
                    e.data = ref_rot(d_arr[LR'(w)], int'(r_arr[LR'(w)]));
                    e.rot  = r_arr[LR'(w)];
                    sb.push_back(e);
                    m_v  = 1'b1;
                    m_lg = w;
                end else if (yumi_i) begin
                    m_v = 1'b0;
                end
            end
        end
    end

    // Monitor: every consumed result is compared with the scoreboard head.
    initial begin : monitor
        res_t e;
        forever begin
            @(negedge clk);
            if (reset_n && v_o && yumi_i) begin
                chk("sb_nonempty", 64'(sb.size() > 0), 64'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_id",   64'(id_o),   64'(e.id));
                    chk("out_data", 64'(data_o), 64'(e.data));
                    chk("out_rot",  64'(rot_o),  64'(e.rot));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic rot_case(int r, logic [W-1:0] exp);
        d_arr[0] = 32'h1234_5678;
        r_arr[0] = LW'(r);
        cyc();
        chk($sformatf("t4_rot%0d", r), 64'(data_o), 64'(exp));
    endtask

    initial begin : driver
        int k;
        reset_n   = 1'b0;
        v_i       = '0;
        want_yumi = 1'b0;
        for (int i = 0; i < N; i++) begin
            d_arr[i] = '0;
            r_arr[i] = '0;
        end
        cyc();
        cyc();
        chk("rst_v_o",    64'(v_o),     64'(0));
        chk("rst_data_o", 64'(data_o),  64'(0));
        chk("rst_id_o",   64'(id_o),    64'(0));
        chk("rst_rot_o",  64'(rot_o),   64'(0));
        chk("rst_ready",  64'(ready_o), 64'(0));
        reset_n = 1'b1;

        // Single request, one-cycle latency.
        v_i = 4'b0001; d_arr[0] = 32'h8000_0001; r_arr[0] = 5'd1; want_yumi = 1'b1;
        cyc();
        chk("t1_v",    64'(v_o),    64'(1));
        chk("t1_data", 64'(data_o), 64'(32'hC000_0000));
        chk("t1_id",   64'(id_o),   64'(0));
        v_i = '0;
        cyc();
        chk("t1_drain", 64'(v_o), 64'(0));

        // All requesting: strict rotation 0,1,2,3,0.
        do_reset();
        d_arr[0] = 32'hA5A5_0000; d_arr[1] = 32'h0000_0002;
        d_arr[2] = 32'h1234_5678; d_arr[3] = 32'h0000_000F;
        for (int i = 0; i < N; i++) r_arr[i] = LW'(i);
        v_i = 4'b1111; want_yumi = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t2_id", 64'(id_o), 64'(i % N));
            if (i == 3) chk("t2_data3", 64'(data_o), 64'(32'hE000_0001));
        end

        // Backpressure for 5 cycles, then release with no bubble.
        v_i = 4'b0110; want_yumi = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_ready_stall", 64'(ready_o), 64'(0));
            chk("t3_id_hold",     64'(id_o),    64'(0));
            chk("t3_data_hold",   64'(data_o),  64'(32'hA5A5_0000));
            cyc();
        end
        want_yumi = 1'b1;
        #1;
        chk("t3_ready_release", 64'(ready_o), 64'(4'b0010));
        cyc();
        chk("t3_id1",   64'(id_o),   64'(1));
        chk("t3_data1", 64'(data_o), 64'(32'h0000_0001));
        cyc();
        chk("t3_v_nobubble", 64'(v_o),  64'(1));
        chk("t3_id2",        64'(id_o), 64'(2));

        // Boundary rotate amounts, then a full sweep.
        v_i = 4'b0001;
        rot_case(0,  32'h1234_5678);
        rot_case(4,  32'h8123_4567);
        rot_case(31, 32'h2468_ACF0);
        for (int r = 0; r < W; r++) begin
            k = int'($urandom_range(0, N - 1));
            v_i = '0;
            v_i[LR'(k)] = 1'b1;
            d_arr[LR'(k)] = $urandom;
            r_arr[LR'(k)] = LW'(r);
            cyc();
        end

        // Lone requester 2, then 0 overtakes it.
        v_i = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_id2", 64'(id_o), 64'(2));
        end
        v_i = 4'b0101;
        cyc();
        chk("t5_id0", 64'(id_o), 64'(0));

        // Asynchronous reset mid-stream drops the pending result.
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t6_v_o",   64'(v_o),     64'(0));
        chk("t6_data",  64'(data_o),  64'(0));
        chk("t6_id",    64'(id_o),    64'(0));
        chk("t6_ready", 64'(ready_o), 64'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        v_i = 4'b1001;
        cyc();
        chk("t6_first", 64'(id_o), 64'(0));
        cyc();
        chk("t6_second", 64'(id_o), 64'(3));

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            v_i = N'($urandom);
            for (int j = 0; j < N; j++) begin
                d_arr[j] = $urandom;
                r_arr[j] = LW'($urandom);
            end
            want_yumi = ($urandom_range(0, 3) != 0);
            cyc();
        end

        v_i = '0; want_yumi = 1'b1;
        repeat (3) cyc();
        chk("sb_drained", 64'(sb.size()), 64'(0));
        chk("final_v_o",  64'(v_o),       64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
